// File: rtl/switch_pkg.sv
// Types shared by the switch controllers.
package switch_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } t_arbState;

endpackage

// File: rtl/switch_egress_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible port at or above the pointer, with wrap.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int g_DEVICES = 4,
  parameter int g_IDX_W   = $clog2(g_DEVICES)
) (
  input  logic [g_DEVICES-1:0] eligible,
  input  logic [g_IDX_W-1:0]   pointer,
  output logic                 any_valid,
  output logic [g_IDX_W-1:0]   winner_idx
);

  logic [g_IDX_W-1:0] cand;

  // Scan from the farthest candidate back to the pointer so the nearest one wins last.
  always_comb begin
    any_valid  = 1'b0;
    winner_idx = '0;
    cand       = '0;
    for (int i = g_DEVICES - 1; i >= 0; i--) begin
      cand = g_IDX_W'((int'(pointer) + i) % g_DEVICES);
      if (eligible[cand]) begin
        any_valid  = 1'b1;
        winner_idx = cand;
      end
    end
  end

endmodule

// File: rtl/switch_egress_arbiter.sv
// Packet-atomic round-robin owner of the shared egress path.
// Optional stall watchdog enabled by defining SWITCH_ARB_WATCHDOG_EN.
module switch_egress_arbiter
  import switch_pkg::*;
#(
  parameter  int g_DEVICES = 4,
  parameter  int g_TIMEOUT = 1024,
  localparam int g_IDX_W   = $clog2(g_DEVICES)
) (
  input  logic                 i_clk,
  input  logic                 i_resetN,
  input  logic [g_DEVICES-1:0] i_portEnable,
  input  logic [g_DEVICES-1:0] i_req,
  input  logic [g_DEVICES-1:0] i_valid,
  input  logic [g_DEVICES-1:0] i_eop,
  input  logic                 i_outReady,
  output logic [g_DEVICES-1:0] o_txReady,
  output logic                 o_grantValid,
  output logic [g_IDX_W-1:0]   o_grantIdx,
  output logic                 o_outValid,
  output logic                 o_timeout
);

  t_arbState          state, state_nxt;
  logic [g_IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic [g_IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [g_IDX_W-1:0] ptr_after_grant;
  logic               timeout_q, timeout_nxt;
  logic               any_valid;
  logic [g_IDX_W-1:0] winner_idx;
  logic               busy;
  logic               accept;
  logic               expire;

  assign busy   = (state == ARB_BUSY);
  assign accept = busy & i_valid[grant_idx] & i_outReady;

  rr_arbiter #(
    .g_DEVICES (g_DEVICES),
    .g_IDX_W   (g_IDX_W)
  ) u_rr (
    .eligible   (i_req & i_portEnable),
    .pointer    (rr_ptr),
    .any_valid  (any_valid),
    .winner_idx (winner_idx)
  );

  assign ptr_after_grant = (grant_idx == g_IDX_W'(g_DEVICES - 1)) ? '0
                                                                   : grant_idx + g_IDX_W'(1);

`ifdef SWITCH_ARB_WATCHDOG_EN
  localparam int c_CNT_W = (g_TIMEOUT > 2) ? $clog2(g_TIMEOUT) : 1;

  logic [c_CNT_W-1:0] stall_cnt;

  // Held at zero outside BUSY so every new grant starts a fresh stall window.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      stall_cnt <= '0;
    end else if (!busy || accept) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + c_CNT_W'(1);
    end
  end

  assign expire = busy & ~accept & (stall_cnt == c_CNT_W'(g_TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^g_TIMEOUT;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // An EOP accept takes priority over a coincident watchdog expiry.
  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    timeout_nxt   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_valid) begin
          state_nxt     = ARB_BUSY;
          grant_idx_nxt = winner_idx;
        end
      end
      ARB_BUSY: begin
        if (accept && i_eop[grant_idx]) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = ptr_after_grant;
        end else if (expire) begin
          state_nxt   = ARB_IDLE;
          rr_ptr_nxt  = ptr_after_grant;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign o_grantValid = busy;
  assign o_grantIdx   = grant_idx;
  assign o_timeout    = timeout_q;
  assign o_txReady    = (busy && i_outReady) ? (g_DEVICES'(1) << grant_idx) : '0;
  assign o_outValid   = busy & i_valid[grant_idx];

endmodule
